// File: rtl/add_serial_ctrl.sv
`default_nettype none
// ============================================================================
// add_serial_ctrl : 2-entry operand FIFO, single-issue sequencer and result
//                   collector placed in front of the add_serial adder.
// Revision: 1.0
// ============================================================================
module add_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int LAT   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_tag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [4:0] c_lat = 5'(LAT);

  state_t           r_state;
  logic [4:0]       r_lat_cnt;
  logic [WIDTH-1:0] r_fifo_a [2];
  logic [WIDTH-1:0] r_fifo_b [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign in_ready = (r_count != 2'd2);
  assign w_push   = in_valid && in_ready;
  // The head entry is the in-flight op, so it is released only at capture.
  assign w_pop    = (r_state == WAIT) && (r_lat_cnt == c_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_fifo_a[0] <= '0;
      r_fifo_a[1] <= '0;
      r_fifo_b[0] <= '0;
      r_fifo_b[1] <= '0;
    end else begin
      if (w_push) begin
        r_fifo_a[r_wr_ptr] <= in_a;
        r_fifo_b[r_wr_ptr] <= in_b;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= 5'd0;
      add_en    <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_count != 2'd0) begin
            add_a   <= r_fifo_a[r_rd_ptr];
            add_b   <= r_fifo_b[r_rd_ptr];
            add_en  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          add_en    <= 1'b0;
          r_lat_cnt <= 5'd0;
          r_state   <= WAIT;
        end
        WAIT: begin
          // add_a/add_b stay untouched here: the adder reads them live.
          if (r_lat_cnt == c_lat) begin
            out_sum   <= add_out;
            out_valid <= 1'b1;
            r_state   <= HOLD;
          end else begin
            r_lat_cnt <= r_lat_cnt + 5'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_tag   <= out_tag + 4'd1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
